// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-client memory arbiter.
// State encoding is fixed so it can be observed on debug taps.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIfBusy  = 2'd1,
        StLsBusy  = 2'd2,
        StIfDrain = 2'd3
    } arb_state_e;

    localparam logic [2:0]  LEN_BYTE       = 3'b000;
    localparam logic [2:0]  LEN_HALF       = 3'b001;
    localparam logic [2:0]  LEN_WORD       = 3'b010;
    localparam int unsigned LEN_SIGNED_BIT = 2;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store clients onto the single byte-serial controller port.
// Handles branch flush of an in-flight fetch and bounds fetch starvation.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        ls_valid,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_len,
    input  logic [31:0] ls_data,
    output logic        ls_ready,
    output logic [31:0] ls_res,
    output logic        mem_valid,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_len,
    output logic [31:0] mem_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_res
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    arb_state_e  state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [2:0]  mem_len_q, mem_len_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic done;
    logic can_grant;
    logic if_cand;
    logic ls_cand;
    logic grant_if;
    logic grant_ls;

    always_comb begin
        done      = rdy_in && mem_ready;
        can_grant = 1'b0;
        if_cand   = if_valid && !flush;
        ls_cand   = ls_valid;
        // The client completing this cycle still shows valid; it must not be re-granted.
        case (state_q)
            StIdle:               can_grant = 1'b1;
            StIfBusy, StIfDrain: begin
                can_grant = done;
                if_cand   = 1'b0;
            end
            StLsBusy: begin
                can_grant = done;
                ls_cand   = 1'b0;
            end
            default:              can_grant = 1'b0;
        endcase
        grant_if = can_grant && if_cand && (!ls_cand || (streak_q == StarveMax));
        grant_ls = can_grant && ls_cand && !grant_if;
    end

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_len_d   = mem_len_q;
        mem_data_d  = mem_data_q;

        if (grant_if) begin
            state_d     = StIfBusy;
            mem_valid_d = 1'b1;
            mem_wr_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_len_d   = LEN_WORD;
            mem_data_d  = 32'd0;
        end else if (grant_ls) begin
            state_d     = StLsBusy;
            mem_valid_d = 1'b1;
            mem_wr_d    = ls_wr;
            mem_addr_d  = ls_addr;
            mem_len_d   = ls_len;
            mem_data_d  = ls_data;
        end else if ((state_q != StIdle) && done) begin
            state_d     = StIdle;
            mem_valid_d = 1'b0;
        end else if ((state_q == StIfBusy) && flush) begin
            // Transfer cannot be aborted; keep mem_valid and swallow the result.
            state_d = StIfDrain;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!if_valid || grant_if) begin
            streak_d = 4'd0;
        end else if (grant_ls && if_cand && (streak_q < StarveMax)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            streak_q    <= 4'd0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_len_q   <= 3'd0;
            mem_data_q  <= 32'd0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_valid_q <= mem_valid_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_len_q   <= mem_len_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign if_ready  = !rst_in && done && (state_q == StIfBusy) && !flush;
    assign ls_ready  = !rst_in && done && (state_q == StLsBusy);
    assign if_data   = mem_res;
    assign ls_res    = mem_res;

    assign mem_valid = mem_valid_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_len   = mem_len_q;
    assign mem_data  = mem_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays both clients and the controller.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        ls_valid;
    logic        ls_wr;
    logic [31:0] ls_addr;
    logic [2:0]  ls_len;
    logic [31:0] ls_data;
    logic        ls_ready;
    logic [31:0] ls_res;
    logic        mem_valid;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [2:0]  mem_len;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [31:0] mem_res;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush     (flush),
        .if_valid  (if_valid),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_data   (if_data),
        .ls_valid  (ls_valid),
        .ls_wr     (ls_wr),
        .ls_addr   (ls_addr),
        .ls_len    (ls_len),
        .ls_data   (ls_data),
        .ls_ready  (ls_ready),
        .ls_res    (ls_res),
        .mem_valid (mem_valid),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .mem_res   (mem_res)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] st();
        return 32'(dut.state_q);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        flush     = 1'b0;
        if_valid  = 1'b0;
        if_addr   = 32'd0;
        ls_valid  = 1'b0;
        ls_wr     = 1'b0;
        ls_addr   = 32'd0;
        ls_len    = 3'd0;
        ls_data   = 32'd0;
        mem_ready = 1'b0;
        mem_res   = 32'd0;

        // Reset state
        #1;
        check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_state", st(), 32'd0);
        tick();
        tick();
        rst_in = 1'b0;

        // 1: single fetch, 4-cycle controller latency
        if_valid = 1'b1;
        if_addr  = 32'h0000_1000;
        #1;
        check_eq("t1_no_valid_same_cycle", 32'(mem_valid), 32'd0);
        tick();
        check_eq("t1_mem_valid", 32'(mem_valid), 32'd1);
        check_eq("t1_mem_len", 32'(mem_len), 32'd2);
        check_eq("t1_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("t1_mem_addr", mem_addr, 32'h0000_1000);
        check_eq("t1_state", st(), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t1_wait_valid", 32'(mem_valid), 32'd1);
            check_eq("t1_wait_if_ready", 32'(if_ready), 32'd0);
        end
        mem_ready = 1'b1;
        mem_res   = 32'h00C5_8593;
        #1;
        check_eq("t1_if_ready", 32'(if_ready), 32'd1);
        check_eq("t1_if_data", if_data, 32'h00C5_8593);
        tick();
        mem_ready = 1'b0;
        if_valid  = 1'b0;
        check_eq("t1_valid_drop", 32'(mem_valid), 32'd0);
        check_eq("t1_idle", st(), 32'd0);
        check_eq("t1_if_ready_low", 32'(if_ready), 32'd0);

        // 2: contention, load first then fetch back-to-back
        if_valid = 1'b1;
        if_addr  = 32'h0000_1004;
        ls_valid = 1'b1;
        ls_wr    = 1'b0;
        ls_len   = 3'b100;
        ls_addr  = 32'h0000_2003;
        tick();
        check_eq("t2_ls_first", st(), 32'd2);
        check_eq("t2_mem_addr", mem_addr, 32'h0000_2003);
        check_eq("t2_mem_len", 32'(mem_len), 32'd4);
        check_eq("t2_streak", 32'(dut.streak_q), 32'd1);
        tick();
        mem_ready = 1'b1;
        mem_res   = 32'hFFFF_FF80;
        #1;
        check_eq("t2_ls_ready", 32'(ls_ready), 32'd1);
        check_eq("t2_ls_res", ls_res, 32'hFFFF_FF80);
        check_eq("t2_if_ready_quiet", 32'(if_ready), 32'd0);
        tick();
        mem_ready = 1'b0;
        ls_valid  = 1'b0;
        check_eq("t2_b2b_state", st(), 32'd1);
        check_eq("t2_b2b_valid", 32'(mem_valid), 32'd1);
        check_eq("t2_b2b_addr", mem_addr, 32'h0000_1004);
        check_eq("t2_b2b_len", 32'(mem_len), 32'd2);
        check_eq("t2_streak_clr", 32'(dut.streak_q), 32'd0);
        mem_ready = 1'b1;
        mem_res   = 32'h1111_2222;
        #1;
        check_eq("t2_if_ready", 32'(if_ready), 32'd1);
        tick();
        mem_ready = 1'b0;
        if_valid  = 1'b0;
        check_eq("t2_idle", st(), 32'd0);

        // 3: starvation; flush at each ls completion keeps fetch pending but ineligible
        if_valid = 1'b1;
        if_addr  = 32'h0000_3000;
        ls_valid = 1'b1;
        ls_wr    = 1'b0;
        ls_len   = 3'b010;
        ls_addr  = 32'h0000_4000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq("t3_ls_grant", st(), 32'd2);
            check_eq("t3_streak", 32'(dut.streak_q), 32'(k));
            mem_ready = 1'b1;
            flush     = 1'b1;
            #1;
            check_eq("t3_ls_ready", 32'(ls_ready), 32'd1);
            tick();
            mem_ready = 1'b0;
            flush     = 1'b0;
            check_eq("t3_idle", st(), 32'd0);
        end
        tick();
        check_eq("t3_fetch_forced", st(), 32'd1);
        check_eq("t3_fetch_addr", mem_addr, 32'h0000_3000);
        check_eq("t3_streak_zero", 32'(dut.streak_q), 32'd0);
        ls_valid  = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("t3_if_ready", 32'(if_ready), 32'd1);
        tick();
        mem_ready = 1'b0;
        if_valid  = 1'b0;
        check_eq("t3_end_idle", st(), 32'd0);

        // 4: flush one cycle after fetch grant, queued store granted at drain completion
        if_valid = 1'b1;
        if_addr  = 32'h0000_5000;
        tick();
        check_eq("t4_if_busy", st(), 32'd1);
        flush    = 1'b1;
        ls_valid = 1'b1;
        ls_wr    = 1'b1;
        ls_addr  = 32'h0000_6000;
        ls_len   = 3'b001;
        ls_data  = 32'h0000_ABCD;
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        check_eq("t4_drain", st(), 32'd3);
        check_eq("t4_valid_held", 32'(mem_valid), 32'd1);
        check_eq("t4_addr_held", mem_addr, 32'h0000_5000);
        tick();
        check_eq("t4_still_drain", st(), 32'd3);
        mem_ready = 1'b1;
        mem_res   = 32'hDEAD_BEEF;
        #1;
        check_eq("t4_no_if_ready", 32'(if_ready), 32'd0);
        check_eq("t4_no_ls_ready", 32'(ls_ready), 32'd0);
        tick();
        mem_ready = 1'b0;
        check_eq("t4_store_grant", st(), 32'd2);
        check_eq("t4_mem_wr", 32'(mem_wr), 32'd1);
        check_eq("t4_mem_addr", mem_addr, 32'h0000_6000);
        check_eq("t4_mem_data", mem_data, 32'h0000_ABCD);
        check_eq("t4_mem_len", 32'(mem_len), 32'd1);
        mem_ready = 1'b1;
        #1;
        check_eq("t4_ls_ready", 32'(ls_ready), 32'd1);
        tick();
        mem_ready = 1'b0;
        ls_valid  = 1'b0;
        ls_wr     = 1'b0;
        check_eq("t4_idle", st(), 32'd0);

        // 5: flush coincident with fetch completion
        if_valid = 1'b1;
        if_addr  = 32'h0000_7000;
        tick();
        check_eq("t5_if_busy", st(), 32'd1);
        mem_ready = 1'b1;
        flush     = 1'b1;
        #1;
        check_eq("t5_if_ready_supp", 32'(if_ready), 32'd0);
        tick();
        mem_ready = 1'b0;
        flush     = 1'b0;
        if_valid  = 1'b0;
        check_eq("t5_no_regrant", st(), 32'd0);
        check_eq("t5_valid_low", 32'(mem_valid), 32'd0);

        // 6: rdy_in low freezes completion
        ls_valid = 1'b1;
        ls_addr  = 32'h0000_8000;
        ls_len   = 3'b000;
        tick();
        check_eq("t6_ls_busy", st(), 32'd2);
        rdy_in    = 1'b0;
        mem_ready = 1'b1;
        mem_res   = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t6_frozen_ls_ready", 32'(ls_ready), 32'd0);
            tick();
            check_eq("t6_frozen_state", st(), 32'd2);
        end
        rdy_in = 1'b1;
        #1;
        check_eq("t6_ls_ready", 32'(ls_ready), 32'd1);
        check_eq("t6_ls_res", ls_res, 32'h0000_0055);
        tick();
        mem_ready = 1'b0;
        ls_valid  = 1'b0;
        check_eq("t6_idle", st(), 32'd0);
        check_eq("t6_ls_ready_low", 32'(ls_ready), 32'd0);

        // Async reset mid LS_BUSY
        ls_valid = 1'b1;
        tick();
        check_eq("t6_rst_pre_busy", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        #2;
        rst_in = 1'b1;
        #1;
        check_eq("t6_rst_valid", 32'(mem_valid), 32'd0);
        check_eq("t6_rst_state", st(), 32'd0);
        check_eq("t6_rst_ls_ready", 32'(ls_ready), 32'd0);
        mem_ready = 1'b0;
        ls_valid  = 1'b0;
        tick();
        rst_in = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly upstream of the byte-serial memory controller.
- Arbitrates between two clients and drives the controller's single request port (valid/wr/addr/len/data), then routes the controller's ready/res back to the winner:
  - the instruction-fetch unit: word reads only;
  - the load/store buffer: byte/half/word, signed/unsigned, read/write.
- Also handles branch flush of an in-flight fetch and prevents fetch starvation.

Parameters:
STARVE_LIMIT, 4, consecutive load/store grants allowed while a fetch is pending before fetch is forced to win (1..15).

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global ready; low freezes all state
flush  in  1  branch mispredict; cancels fetch traffic only
if_valid  in  1  fetch request, held until if_ready
if_addr  in  32  fetch address
if_ready  out  1  one-cycle completion pulse for fetch
if_data  out  32  fetched word, valid when if_ready
ls_valid  in  1  load/store request, held until ls_ready
ls_wr  in  1  1 = store
ls_addr  in  32  byte address
ls_len  in  3  [1:0] 00 byte / 01 half / 10 word; [2] sign-extend
ls_data  in  32  store data
ls_ready  out  1  one-cycle completion pulse for load/store
ls_res  out  32  load result, valid when ls_ready
mem_valid  out  1  request to controller
mem_wr  out  1  to controller
mem_addr  out  32  to controller
mem_len  out  3  to controller
mem_data  out  32  to controller
mem_ready  in  1  controller completion pulse
mem_res  in  32  controller result, valid with mem_ready

Behaviour:
- Reset, asynchronous: state = IDLE, streak = 0, mem_valid/mem_wr = 0, mem_addr/mem_len/mem_data = 0.
  - if_ready and ls_ready are 0 during reset.
  - The controller shares rst_in, so reset mid-transfer needs no drain.
- rdy_in low: no register updates, and if_ready = ls_ready = 0.
- States:
  - IDLE: no request is outstanding.
  - IF_BUSY: fetch is owned by the controller.
  - LS_BUSY: load/store is owned by the controller.
  - IF_DRAIN: a flushed fetch is still completing.
- All mem_* outputs are registered and latched at grant. Client inputs are ignored after grant, so clients may hold them unchanged.
- Fetch is issued as mem_wr = 0, mem_len = 3'b010.
- Grant happens at the edge where the eligible set is non-empty in IDLE, or in the completion cycle of any BUSY/DRAIN state.
  - That edge sets mem_valid = 1 and enters the matching BUSY state.
  - Request in IDLE at cycle t gives mem_valid at t+1.
- Eligibility:
  - fetch is eligible if if_valid && !flush;
  - load/store is eligible if ls_valid.
- Priority:
  - load/store wins by default;
  - fetch wins when streak == STARVE_LIMIT.
- streak:
  - increments on a load/store grant while fetch is eligible, saturating at STARVE_LIMIT;
  - clears on a fetch grant, or whenever if_valid = 0.
- Completion cycle (rdy_in && mem_ready):
  - IF_BUSY: if_ready = !flush. if_data = mem_res combinationally.
  - LS_BUSY: ls_ready = 1. ls_res = mem_res combinationally.
  - IF_DRAIN: no client pulse.
- Back-to-back: in the completion cycle, the client being completed is NOT eligible, because it still shows valid that cycle.
  - The other client may be granted at that edge; otherwise state goes to IDLE and mem_valid goes to 0.
  - The controller ignores valid during its ready cycle, so there is no double issue.
- Flush:
  - In IF_BUSY with no mem_ready: next state is IF_DRAIN. mem_valid stays 1, because a controller transfer cannot be aborted.
  - In IF_DRAIN: completion returns to IDLE (or grants load/store).
  - Flush in the same cycle as fetch completion: if_ready is suppressed.
  - Flush never affects LS_BUSY or a load/store grant.
- IO-mapped stores may stall inside the controller (buffer full); the arbiter simply holds the BUSY state. There is no timeout.
- The arbiter holds at most one outstanding request, and never drops mem_valid before mem_ready.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 0, IF_BUSY = 1, LS_BUSY = 2, IF_DRAIN = 3;
  - len constants: LEN_BYTE = 3'b000, LEN_HALF = 3'b001, LEN_WORD = 3'b010, LEN_SIGNED_BIT = 2.
- No sub-module: grant logic plus streak counter stay inline (≈150 lines).

Test Plan:
1. Single fetch: if_valid, if_addr = 0x1000, model returns 0x00C58593 after 4 cycles -> mem_valid rises 1 cycle after the request, with mem_len = 010 and mem_wr = 0. One if_ready pulse with if_data = 0x00C58593, then mem_valid = 0 next cycle.
2. Contention: if_valid and ls_valid (load, ls_len = 100, ls_addr = 0x2003) in the same cycle -> load/store granted first. In its ready cycle the fetch is granted back-to-back, with no idle cycle and no re-issue of the load.
3. Starvation: ls_valid held continuously with STARVE_LIMIT = 4 and fetch pending -> exactly 4 load/store grants, then fetch granted, then streak = 0.
4. Flush mid-fetch: flush pulses 1 cycle after fetch grant -> mem_valid held until mem_ready, state IF_DRAIN, if_ready never pulses. A queued store is granted at drain completion.
5. Flush coincident with mem_ready in IF_BUSY -> if_ready = 0, and no fetch is re-granted that cycle.
6. rdy_in low for 3 cycles during LS_BUSY with mem_ready high -> ls_ready = 0 throughout. One ls_ready pulse when rdy_in returns. Async rst_in mid-LS_BUSY -> mem_valid = 0 immediately, without waiting for a clock edge.
